// File: rtl/ddr_frame_scheduler.sv
// ddr_frame_scheduler
// Chooses the next DDR line transfer (camera line write or YUV line read),
// arbitrating round-robin between the two requesters. Tracks a ring of
// N_BUF frame segments so that readout never lands on the frame being written.
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_init_calib_complete      DDR ready; no grant while low
//   i_wr_line_avail            write FIFO holds a full line
//   i_rd_line_space            read FIFO can take a full line
//   o_cmd_valid/i_cmd_ready    line command handshake to the DDR engine
//   o_cmd_is_rd, o_cmd_addr    direction and start address of the line
//   o_cmd_beats                beats per line (constant WIDTH/16)
//   i_xfer_done                engine finished the accepted line (1-cycle pulse)
//   o_wr_buf, o_rd_buf         current write / read segment
//   o_rd_active                first frame complete, reads allowed
//   o_wr_frame_done            pulse: last write line of a frame finished
//   o_frame_drop               pulse: finished write frame could not advance
//   o_rd_repeat                pulse: read frame repeats (no newer frame)
module ddr_frame_scheduler #(
  parameter int ADDR_WIDTH = 28,
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int N_BUF      = 4,
  parameter int BEAT_STEP  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_init_calib_complete,
  input  logic                     i_wr_line_avail,
  input  logic                     i_rd_line_space,
  output logic                     o_cmd_valid,
  output logic                     o_cmd_is_rd,
  output logic [ADDR_WIDTH-1:0]    o_cmd_addr,
  output logic [15:0]              o_cmd_beats,
  input  logic                     i_cmd_ready,
  input  logic                     i_xfer_done,
  output logic [$clog2(N_BUF)-1:0] o_wr_buf,
  output logic [$clog2(N_BUF)-1:0] o_rd_buf,
  output logic                     o_rd_active,
  output logic                     o_wr_frame_done,
  output logic                     o_frame_drop,
  output logic                     o_rd_repeat
);

  localparam int BW    = $clog2(N_BUF);
  localparam int LW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BEATS = WIDTH / 16;
  // One line is BEATS beats of BEAT_STEP address units (WIDTH/2 for 8),
  // a segment is HEIGHT such lines.
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(BEATS * BEAT_STEP);
  localparam logic [ADDR_WIDTH-1:0] SEG_SIZE  = ADDR_WIDTH'(BEATS * BEAT_STEP * HEIGHT);
  localparam logic [LW-1:0]         LAST_LINE = LW'(HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_UPDATE} state_t;

  state_t                r_state, w_next;
  logic [LW-1:0]         r_wr_line, r_rd_line;
  logic [ADDR_WIDTH-1:0] r_wr_off, r_rd_off;     // line offset accumulators
  logic [BW-1:0]         r_wr_buf, r_rd_buf;
  logic                  r_last_grant;           // 0 = write, 1 = read
  logic                  r_rd_active;
  logic                  r_cmd_is_rd;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic                  r_wr_frame_done, r_frame_drop, r_rd_repeat;

  logic                  w_wr_cand, w_rd_cand, w_grant, w_grant_rd;
  logic [BW-1:0]         w_wr_nxt, w_rd_nxt;
  logic [ADDR_WIDTH-1:0] w_wr_base, w_rd_base;

  assign w_wr_cand = i_wr_line_avail;
  assign w_rd_cand = r_rd_active & i_rd_line_space;
  // N_BUF is a power of 2, so the ring wrap is the natural BW-bit overflow.
  assign w_wr_nxt  = r_wr_buf + BW'(1);
  assign w_rd_nxt  = r_rd_buf + BW'(1);
  // Constant multiplier only; reduces to shifts/adds.
  assign w_wr_base = SEG_SIZE * ADDR_WIDTH'(r_wr_buf);
  assign w_rd_base = SEG_SIZE * ADDR_WIDTH'(r_rd_buf);

  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_grant_rd = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_init_calib_complete && (w_wr_cand || w_rd_cand)) begin
          w_grant    = 1'b1;
          // Contested: give it to the side that did not win last time.
          w_grant_rd = (w_wr_cand && w_rd_cand) ? ~r_last_grant : w_rd_cand;
          w_next     = S_ISSUE;
        end
      end
      S_ISSUE:  if (i_cmd_ready) w_next = S_WAIT;
      S_WAIT:   if (i_xfer_done) w_next = S_UPDATE;
      S_UPDATE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_wr_line       <= '0;
      r_rd_line       <= '0;
      r_wr_off        <= '0;
      r_rd_off        <= '0;
      r_wr_buf        <= '0;
      r_rd_buf        <= '0;
      r_last_grant    <= 1'b1;
      r_rd_active     <= 1'b0;
      r_cmd_is_rd     <= 1'b0;
      r_cmd_addr      <= '0;
      r_wr_frame_done <= 1'b0;
      r_frame_drop    <= 1'b0;
      r_rd_repeat     <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_wr_frame_done <= 1'b0;
      r_frame_drop    <= 1'b0;
      r_rd_repeat     <= 1'b0;

      if (w_grant) begin
        r_cmd_is_rd  <= w_grant_rd;
        r_last_grant <= w_grant_rd;
        r_cmd_addr   <= w_grant_rd ? (w_rd_base + r_rd_off) : (w_wr_base + r_wr_off);
      end

      if (r_state == S_UPDATE) begin
        if (!r_cmd_is_rd) begin
          if (r_wr_line == LAST_LINE) begin
            r_wr_line       <= '0;
            r_wr_off        <= '0;
            r_rd_active     <= 1'b1;
            r_wr_frame_done <= 1'b1;
            // Never step onto the segment being read; overwrite in place.
            if (w_wr_nxt != r_rd_buf) r_wr_buf <= w_wr_nxt;
            else                      r_frame_drop <= 1'b1;
          end else begin
            r_wr_line <= r_wr_line + LW'(1);
            r_wr_off  <= r_wr_off + LINE_STEP;
          end
        end else begin
          if (r_rd_line == LAST_LINE) begin
            r_rd_line <= '0;
            r_rd_off  <= '0;
            // Never step onto the segment being written; replay instead.
            if (w_rd_nxt != r_wr_buf) r_rd_buf <= w_rd_nxt;
            else                      r_rd_repeat <= 1'b1;
          end else begin
            r_rd_line <= r_rd_line + LW'(1);
            r_rd_off  <= r_rd_off + LINE_STEP;
          end
        end
      end
    end
  end

  assign o_cmd_valid     = (r_state == S_ISSUE);
  assign o_cmd_is_rd     = r_cmd_is_rd;
  assign o_cmd_addr      = r_cmd_addr;
  assign o_cmd_beats     = 16'(BEATS);
  assign o_wr_buf        = r_wr_buf;
  assign o_rd_buf        = r_rd_buf;
  assign o_rd_active     = r_rd_active;
  assign o_wr_frame_done = r_wr_frame_done;
  assign o_frame_drop    = r_frame_drop;
  assign o_rd_repeat     = r_rd_repeat;

endmodule

// File: doc/ddr_frame_scheduler.md
# ddr_frame_scheduler

Frame-buffer scheduler for the UVC DDR3 path. Decides which line transfer the DDR command engine runs next: a camera line write or a YUV line read. Arbitrates between the two requesters and manages a ring of N_BUF frame segments in DDR with write/read buffer pointers, so readout never touches the frame being written. It sits between the line-level FIFO status flags and the DDR command engine that drives the memory-controller app port.

## Interface
Parameters:
- ADDR_WIDTH, 28, DDR app address width
- WIDTH, 1280, pixels per line; multiple of 16
- HEIGHT, 720, lines per frame
- N_BUF, 4, frame segments in the ring; power of 2, ≥2
- BEAT_STEP, 8, address increment per 256-bit beat

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- init_calib_complete  in  1  DDR ready; no command issued while low
- wr_line_avail  in  1  write FIFO holds ≥ one full line (WIDTH/16 beats)
- rd_line_space  in  1  read FIFO has room for ≥ one full line
- cmd_valid  out  1  line command pending to the engine
- cmd_is_rd  out  1  1 = read line, 0 = write line
- cmd_addr  out  ADDR_WIDTH  start address of the line
- cmd_beats  out  16  beats in the line, constant WIDTH/16
- cmd_ready  in  1  engine accepts the command (valid&ready handshake)
- xfer_done  in  1  one-cycle pulse: engine finished the accepted line
- wr_buf  out  log2(N_BUF)  current write segment
- rd_buf  out  log2(N_BUF)  current read segment
- rd_active  out  1  set once the first frame is complete
- wr_frame_done  out  1  pulse on the last write line completing
- frame_drop  out  1  pulse when a finished write frame cannot advance (overwrite)
- rd_repeat  out  1  pulse when the read frame repeats (no newer frame)

## Operation
- Segment base = buf × WIDTH×HEIGHT/2. Line address = base + line × WIDTH/2. The multiply is done on constants or a line accumulator; no runtime multiplier. Addresses wrap modulo 2^ADDR_WIDTH.
- Counters:
  - wr_line and rd_line, range 0..HEIGHT-1.
  - last_grant (0 = write, 1 = read).
- FSM IDLE → ISSUE → WAIT → UPDATE → IDLE.
- IDLE: requires init_calib_complete.
  - Write candidate: wr_line_avail.
  - Read candidate: rd_active & rd_line_space.
  - If both are candidates, grant the one opposite last_grant. If one, grant it. If none, stay.
  - On grant: latch cmd_is_rd and cmd_addr, update last_grant, go to ISSUE.
- ISSUE: cmd_valid=1 with stable fields until cmd_ready, then go to WAIT.
- WAIT: hold until xfer_done, then go to UPDATE. xfer_done outside WAIT is ignored.
- UPDATE, write line: wr_line++.
  - On the last line: wr_line=0, rd_active=1, wr_frame_done pulse.
  - If (wr_buf+1)%N_BUF ≠ rd_buf, advance wr_buf. Otherwise hold wr_buf and pulse frame_drop.
- UPDATE, read line: rd_line++.
  - On the last line: rd_line=0.
  - If (rd_buf+1)%N_BUF ≠ wr_buf, advance rd_buf. Otherwise hold rd_buf and pulse rd_repeat.
- Invariant: once rd_active is set, rd_buf ≠ wr_buf.

## Timing
- Reset values:
  - cmd_valid=0, cmd_is_rd=0, cmd_addr=0, cmd_beats=WIDTH/16.
  - wr_buf=0, rd_buf=0, rd_active=0, all pulses 0.
  - Counters 0, last_grant=1 (first contested grant goes to write). FSM in IDLE.
- cmd_valid rises on the cycle after the IDLE grant edge.
- At most one command is outstanding.
- Minimum 4 cycles per line with cmd_ready and xfer_done immediate.
- Pulses (wr_frame_done, frame_drop, rd_repeat) are one cycle, registered, on the cycle after UPDATE.
- Pointer and counter updates are visible in the IDLE cycle that follows, so the next command uses the new values.
- init_calib_complete falling:
  - Already-issued commands complete normally.
  - No new grant is made while it is low.
- rst mid-transfer: state returns to reset values on the next edge; cmd_valid drops. The engine must be reset in the same cycle.
- Requester flags are sampled only in IDLE. Deassertion during ISSUE or WAIT has no effect.

## Test plan
Bench parameters: WIDTH=32, HEIGHT=2, N_BUF=4. Segment = 32, line step 16, cmd_beats=2.

1. Reset, then wr_line_avail=1, rd_line_space=1, cmd_ready=1, xfer_done one cycle after accept:
   - Writes at addresses 0 and 16.
   - wr_frame_done pulses, wr_buf=1, rd_active=1.
2. Both requesters held high after frame 0:
   - Grants alternate write/read.
   - First read address is 0, write address is 32. Second read is 16, second write is 48.
3. Read-only traffic (wr_line_avail=0) after frame 0:
   - After reading lines 0 and 16, rd_repeat pulses and rd_buf stays 0.
   - Next read address is 0 again.
4. Write-only traffic with rd_buf=0 held:
   - Frames go to wr_buf 1, 2, 3.
   - The next frame end pulses frame_drop and wr_buf stays 3; subsequent writes repeat at 96 and 112.
5. cmd_ready held low for 10 cycles:
   - cmd_valid, cmd_addr and cmd_is_rd are stable throughout.
   - No second grant. xfer_done pulsed during ISSUE is ignored.
6. init_calib_complete=0 with requests pending:
   - No cmd_valid.
   - rst asserted during WAIT: the next cycle shows all outputs at their reset values.
